// File: rtl/clic_irq_arbiter.sv
// rtl/clic_irq_arbiter.sv - CLIC source arbiter: pending latch, priority select, offer/kill handshake
module clic_irq_arbiter #(
    parameter int unsigned NumSrc  = 64,
    localparam int unsigned IdWidth = $clog2(NumSrc)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumSrc-1:0]     irq_src_i,
    input  logic [NumSrc-1:0]     cfg_ie_i,
    input  logic [NumSrc-1:0]     cfg_edge_i,
    input  logic [8*NumSrc-1:0]   cfg_level_i,
    input  logic [2*NumSrc-1:0]   cfg_priv_i,
    output logic                  irq_valid_o,
    input  logic                  irq_ready_i,
    output logic [IdWidth-1:0]    irq_id_o,
    output logic [7:0]            irq_level_o,
    output logic [1:0]            irq_priv_o,
    output logic                  kill_req_o,
    input  logic                  kill_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_KILL  = 2'd2
    } state_t;

    // Machine outranks supervisor outranks user; the reserved encoding ranks as user.
    function automatic logic [1:0] priv_rank(input logic [1:0] priv);
        case (priv)
            2'b11:   priv_rank = 2'd3;
            2'b01:   priv_rank = 2'd1;
            default: priv_rank = 2'd0;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [NumSrc-1:0]   src_q;
    logic [NumSrc-1:0]   ip_q;
    logic [NumSrc-1:0]   elig;

    logic [7:0]          level_arr [NumSrc];
    logic [1:0]          priv_arr  [NumSrc];
    logic [9:0]          key_arr   [NumSrc];

    logic                best_valid_d, best_valid_q;
    logic [IdWidth-1:0]  best_id_d, best_id_q;
    logic [9:0]          best_key_d, best_key_q;

    logic [IdWidth-1:0]  off_id_q;
    logic [7:0]          off_level_q;
    logic [1:0]          off_priv_q;
    logic [9:0]          off_key;

    logic                load_offer;
    logic                accept;

    for (genvar g = 0; g < NumSrc; g++) begin : g_src
        assign level_arr[g] = cfg_level_i[8*g +: 8];
        assign priv_arr[g]  = cfg_priv_i[2*g +: 2];
        assign key_arr[g]   = {priv_rank(priv_arr[g]), level_arr[g]};
    end

    assign elig = ip_q & cfg_ie_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q <= '0;
            ip_q  <= '0;
        end else begin
            src_q <= irq_src_i;
            for (int i = 0; i < NumSrc; i++) begin
                if (!cfg_edge_i[i]) begin
                    ip_q[i] <= irq_src_i[i];
                end else if (irq_src_i[i] && !src_q[i]) begin
                    ip_q[i] <= 1'b1;
                end else if (accept && (off_id_q == IdWidth'(i))) begin
                    ip_q[i] <= 1'b0;
                end
            end
        end
    end

    // Strict greater-than while scanning upward keeps the lowest id on ties.
    always_comb begin
        best_valid_d = 1'b0;
        best_id_d    = '0;
        best_key_d   = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (elig[i] && (!best_valid_d || (key_arr[i] > best_key_d))) begin
                best_valid_d = 1'b1;
                best_id_d    = IdWidth'(i);
                best_key_d   = key_arr[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            best_valid_q <= 1'b0;
            best_id_q    <= '0;
            best_key_q   <= '0;
        end else begin
            best_valid_q <= best_valid_d;
            best_id_q    <= best_id_d;
            best_key_q   <= best_key_d;
        end
    end

    assign off_key = {priv_rank(off_priv_q), off_level_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // best_q lags ip by a cycle, so right after an acceptance it can still name
    // the source just cleared; re-checking eligibility avoids offering it twice.
    always_comb begin
        state_d    = state_q;
        load_offer = 1'b0;
        accept     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (best_valid_q && elig[best_id_q]) begin
                    load_offer = 1'b1;
                    state_d    = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (irq_ready_i) begin
                    accept  = 1'b1;
                    state_d = ST_IDLE;
                end else if ((best_valid_q && (best_key_q > off_key)) || !elig[off_id_q]) begin
                    state_d = ST_KILL;
                end
            end
            ST_KILL: begin
                if (irq_ready_i) begin
                    accept  = 1'b1;
                    state_d = ST_IDLE;
                end else if (kill_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            off_id_q    <= '0;
            off_level_q <= '0;
            off_priv_q  <= '0;
        end else if (load_offer) begin
            off_id_q    <= best_id_q;
            off_level_q <= level_arr[best_id_q];
            off_priv_q  <= priv_arr[best_id_q];
        end
    end

    assign irq_valid_o = (state_q == ST_OFFER) || (state_q == ST_KILL);
    assign kill_req_o  = (state_q == ST_KILL);
    assign irq_id_o    = off_id_q;
    assign irq_level_o = off_level_q;
    assign irq_priv_o  = off_priv_q;

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// tb/tb_clic_irq_arbiter.sv - directed self-checking bench for clic_irq_arbiter
module tb_clic_irq_arbiter;

    localparam int NumSrc  = 64;
    localparam int IdWidth = $clog2(NumSrc);

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [NumSrc-1:0]    irq_src_i;
    logic [NumSrc-1:0]    cfg_ie_i;
    logic [NumSrc-1:0]    cfg_edge_i;
    logic [8*NumSrc-1:0]  cfg_level_i;
    logic [2*NumSrc-1:0]  cfg_priv_i;
    logic                 irq_valid_o;
    logic                 irq_ready_i;
    logic [IdWidth-1:0]   irq_id_o;
    logic [7:0]           irq_level_o;
    logic [1:0]           irq_priv_o;
    logic                 kill_req_o;
    logic                 kill_ack_i;

    int n_checks = 0;
    int n_fail   = 0;

    clic_irq_arbiter #(.NumSrc(NumSrc)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .irq_src_i   (irq_src_i),
        .cfg_ie_i    (cfg_ie_i),
        .cfg_edge_i  (cfg_edge_i),
        .cfg_level_i (cfg_level_i),
        .cfg_priv_i  (cfg_priv_i),
        .irq_valid_o (irq_valid_o),
        .irq_ready_i (irq_ready_i),
        .irq_id_o    (irq_id_o),
        .irq_level_o (irq_level_o),
        .irq_priv_o  (irq_priv_o),
        .kill_req_o  (kill_req_o),
        .kill_ack_i  (kill_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        irq_src_i   = '0;
        cfg_ie_i    = '0;
        cfg_edge_i  = '0;
        cfg_level_i = '0;
        cfg_priv_i  = '0;
        irq_ready_i = 1'b0;
        kill_ack_i  = 1'b0;
        tick(2);
        rst_ni = 1'b1;
        tick(1);
    endtask

    task automatic set_src(input int id, input logic edge_mode, input logic [7:0] lvl, input logic [1:0] priv);
        cfg_ie_i[id]           = 1'b1;
        cfg_edge_i[id]         = edge_mode;
        cfg_level_i[8*id +: 8] = lvl;
        cfg_priv_i[2*id +: 2]  = priv;
    endtask

    task automatic accept_offer();
        irq_ready_i = 1'b1;
        tick(1);
        irq_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({irq_valid_o, kill_req_o, irq_id_o, irq_level_o, irq_priv_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b k=%b id=%0d lvl=%h priv=%0d want all 0",
                     irq_valid_o, kill_req_o, irq_id_o, irq_level_o, irq_priv_o);
        end
    endtask

    task automatic test_idle_ignore();
        do_reset();
        irq_ready_i = 1'b1;
        kill_ack_i  = 1'b1;
        tick(3);
        irq_ready_i = 1'b0;
        kill_ack_i  = 1'b0;
        n_checks++;
        if (irq_valid_o !== 1'b0 || kill_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore: got v=%b k=%b want 0 0", irq_valid_o, kill_req_o);
        end
    endtask

    task automatic test_edge_offer();
        do_reset();
        set_src(5, 1'b1, 8'h40, 2'b11);
        irq_src_i[5] = 1'b1;
        tick(1);
        irq_src_i[5] = 1'b0;
        n_checks++;
        if (dut.ip_q[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL edge_ip_set: got %b want 1", dut.ip_q[5]);
        end
        tick(1);
        n_checks++;
        if (irq_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_latency_c2: got valid=%b want 0", irq_valid_o);
        end
        tick(1);
        n_checks++;
        if ({irq_valid_o, irq_id_o, irq_level_o, irq_priv_o} !== {1'b1, 6'd5, 8'h40, 2'b11}) begin
            n_fail++;
            $display("FAIL edge_offer_c3: got v=%b id=%0d lvl=%h priv=%0d want 1 5 40 3",
                     irq_valid_o, irq_id_o, irq_level_o, irq_priv_o);
        end
        tick(1);
        accept_offer();
        n_checks++;
        if (irq_valid_o !== 1'b0 || dut.ip_q[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_accept: got valid=%b ip=%b want 0 0", irq_valid_o, dut.ip_q[5]);
        end
        tick(3);
        n_checks++;
        if (irq_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_no_reoffer: got valid=%b want 0", irq_valid_o);
        end
    endtask

    task automatic test_priority();
        do_reset();
        set_src(3, 1'b1, 8'hFF, 2'b01);
        set_src(9, 1'b1, 8'h01, 2'b11);
        irq_src_i[3] = 1'b1;
        irq_src_i[9] = 1'b1;
        tick(1);
        irq_src_i = '0;
        tick(2);
        n_checks++;
        if ({irq_valid_o, irq_id_o, irq_level_o, irq_priv_o} !== {1'b1, 6'd9, 8'h01, 2'b11}) begin
            n_fail++;
            $display("FAIL prio_rank: got v=%b id=%0d lvl=%h priv=%0d want 1 9 01 3",
                     irq_valid_o, irq_id_o, irq_level_o, irq_priv_o);
        end
        accept_offer();
        tick(2);
        n_checks++;
        if ({irq_valid_o, irq_id_o, kill_req_o} !== {1'b1, 6'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_second: got v=%b id=%0d k=%b want 1 3 0", irq_valid_o, irq_id_o, kill_req_o);
        end
        accept_offer();

        do_reset();
        set_src(2, 1'b1, 8'h80, 2'b11);
        set_src(7, 1'b1, 8'h80, 2'b11);
        irq_src_i[2] = 1'b1;
        irq_src_i[7] = 1'b1;
        tick(1);
        irq_src_i = '0;
        tick(2);
        n_checks++;
        if (irq_valid_o !== 1'b1 || irq_id_o !== 6'd2) begin
            n_fail++;
            $display("FAIL prio_tie: got v=%b id=%0d want 1 2", irq_valid_o, irq_id_o);
        end
        accept_offer();
        tick(2);
        n_checks++;
        if (irq_valid_o !== 1'b1 || irq_id_o !== 6'd7) begin
            n_fail++;
            $display("FAIL prio_tie_next: got v=%b id=%0d want 1 7", irq_valid_o, irq_id_o);
        end
        accept_offer();
    endtask

    task automatic test_kill_preempt();
        do_reset();
        set_src(4, 1'b1, 8'h10, 2'b11);
        set_src(6, 1'b1, 8'h20, 2'b11);
        irq_src_i[4] = 1'b1;
        tick(1);
        irq_src_i[4] = 1'b0;
        tick(2);
        n_checks++;
        if (irq_valid_o !== 1'b1 || irq_id_o !== 6'd4) begin
            n_fail++;
            $display("FAIL kill_first_offer: got v=%b id=%0d want 1 4", irq_valid_o, irq_id_o);
        end
        irq_src_i[6] = 1'b1;
        tick(1);
        irq_src_i[6] = 1'b0;
        tick(1);
        n_checks++;
        if (kill_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_early: got kill_req=%b want 0", kill_req_o);
        end
        tick(1);
        n_checks++;
        if ({kill_req_o, irq_valid_o, irq_id_o, irq_level_o} !== {1'b1, 1'b1, 6'd4, 8'h10}) begin
            n_fail++;
            $display("FAIL kill_req: got k=%b v=%b id=%0d lvl=%h want 1 1 4 10",
                     kill_req_o, irq_valid_o, irq_id_o, irq_level_o);
        end
        tick(1);
        n_checks++;
        if (kill_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL kill_hold: got kill_req=%b want 1", kill_req_o);
        end
        kill_ack_i = 1'b1;
        tick(1);
        kill_ack_i = 1'b0;
        n_checks++;
        if ({irq_valid_o, kill_req_o, dut.ip_q[4]} !== 3'b001) begin
            n_fail++;
            $display("FAIL kill_ack: got v=%b k=%b ip4=%b want 0 0 1", irq_valid_o, kill_req_o, dut.ip_q[4]);
        end
        tick(1);
        n_checks++;
        if ({irq_valid_o, irq_id_o, irq_level_o} !== {1'b1, 6'd6, 8'h20}) begin
            n_fail++;
            $display("FAIL kill_next_offer: got v=%b id=%0d lvl=%h want 1 6 20", irq_valid_o, irq_id_o, irq_level_o);
        end
        accept_offer();
        tick(2);
        n_checks++;
        if (irq_valid_o !== 1'b1 || irq_id_o !== 6'd4) begin
            n_fail++;
            $display("FAIL kill_reoffer_4: got v=%b id=%0d want 1 4", irq_valid_o, irq_id_o);
        end
        accept_offer();
    endtask

    task automatic test_level_drop();
        do_reset();
        set_src(1, 1'b0, 8'h05, 2'b11);
        irq_src_i[1] = 1'b1;
        tick(3);
        n_checks++;
        if (irq_valid_o !== 1'b1 || irq_id_o !== 6'd1) begin
            n_fail++;
            $display("FAIL level_offer: got v=%b id=%0d want 1 1", irq_valid_o, irq_id_o);
        end
        irq_src_i[1] = 1'b0;
        tick(1);
        n_checks++;
        if (kill_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL level_kill_early: got kill_req=%b want 0", kill_req_o);
        end
        tick(1);
        n_checks++;
        if (kill_req_o !== 1'b1 || irq_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL level_kill: got k=%b v=%b want 1 1", kill_req_o, irq_valid_o);
        end
        irq_ready_i = 1'b1;
        kill_ack_i  = 1'b1;
        tick(1);
        irq_ready_i = 1'b0;
        kill_ack_i  = 1'b0;
        n_checks++;
        if ({irq_valid_o, kill_req_o, dut.ip_q[1]} !== 3'b000) begin
            n_fail++;
            $display("FAIL level_accept: got v=%b k=%b ip1=%b want 0 0 0", irq_valid_o, kill_req_o, dut.ip_q[1]);
        end
    endtask

    task automatic test_edge_reassert();
        do_reset();
        set_src(8, 1'b1, 8'h30, 2'b01);
        irq_src_i[8] = 1'b1;
        tick(1);
        irq_src_i[8] = 1'b0;
        tick(2);
        n_checks++;
        if ({irq_valid_o, irq_id_o, irq_priv_o} !== {1'b1, 6'd8, 2'b01}) begin
            n_fail++;
            $display("FAIL reassert_offer: got v=%b id=%0d priv=%0d want 1 8 1", irq_valid_o, irq_id_o, irq_priv_o);
        end
        irq_ready_i  = 1'b1;
        irq_src_i[8] = 1'b1;
        tick(1);
        irq_ready_i  = 1'b0;
        irq_src_i[8] = 1'b0;
        n_checks++;
        if (irq_valid_o !== 1'b0 || dut.ip_q[8] !== 1'b1) begin
            n_fail++;
            $display("FAIL reassert_set_wins: got v=%b ip8=%b want 0 1", irq_valid_o, dut.ip_q[8]);
        end
        tick(1);
        n_checks++;
        if (irq_valid_o !== 1'b1 || irq_id_o !== 6'd8) begin
            n_fail++;
            $display("FAIL reassert_reoffer: got v=%b id=%0d want 1 8", irq_valid_o, irq_id_o);
        end
        accept_offer();
        n_checks++;
        if (dut.ip_q[8] !== 1'b0) begin
            n_fail++;
            $display("FAIL reassert_clear: got ip8=%b want 0", dut.ip_q[8]);
        end
    endtask

    task automatic test_reset_in_kill();
        do_reset();
        set_src(1, 1'b0, 8'h05, 2'b11);
        irq_src_i[1] = 1'b1;
        tick(3);
        irq_src_i[1] = 1'b0;
        tick(2);
        n_checks++;
        if (kill_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_kill_setup: got kill_req=%b want 1", kill_req_o);
        end
        #1;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (irq_valid_o !== 1'b0 || kill_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: got v=%b k=%b want 0 0", irq_valid_o, kill_req_o);
        end
        tick(1);
        rst_ni = 1'b1;
        tick(4);
        n_checks++;
        if ({irq_valid_o, kill_req_o, irq_id_o, irq_level_o, irq_priv_o} !== '0) begin
            n_fail++;
            $display("FAIL rst_after_release: got v=%b k=%b id=%0d lvl=%h priv=%0d want all 0",
                     irq_valid_o, kill_req_o, irq_id_o, irq_level_o, irq_priv_o);
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_edge_offer();
        test_priority();
        test_kill_preempt();
        test_level_drop();
        test_edge_reassert();
        test_reset_in_kill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
